uart_rx_oversampler: RTL and testbench

UART_RX_OVERSAMPLER -- requirements
Module: uart_rx_oversampler

---
 rtl/uart_rx_oversampler_pkg.sv | 22 ++
 rtl/uart_rx_oversampler_rx_sync.sv | 28 ++
 rtl/uart_rx_oversampler.sv | 156 +++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_oversampler_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// sample-point positions within a bit period and the majority voter.
package uart_rx_oversampler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Tick-counter values at which the line is sampled; the bit value is
  // decided on the SAMPLE_DECIDE tick using the two earlier samples.
  localparam logic [3:0] SAMPLE_A      = 4'd7;
  localparam logic [3:0] SAMPLE_B      = 4'd8;
  localparam logic [3:0] SAMPLE_DECIDE = 4'd9;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversampler_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line. Both flops reset to
// the idle level so no false start edge is seen coming out of reset.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two flops to settle metastability.
  // NOTE: sequential state always uses <=, so every flop samples the
  // pre-edge value of the others and the chain stays two stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receiver that oversamples each bit on a 16x-baud tick, votes 2-of-3
// around mid-bit, and hands completed bytes to a consumer with ack.
module uart_rx_oversampler
  import uart_rx_oversampler_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_16bd,
  input  logic                 rx,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int         BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0] TICK_WRAP = 4'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 samp_a_q, samp_a_d;
  logic                 samp_b_q, samp_b_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 busy_q;
  logic                 rx_prev_q;
  logic                 bd_prev_q;

  logic rx_s;
  logic tick;
  logic rx_fall;
  logic decide;
  logic wrap;
  logic maj;

  rx_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  assign tick    = clk_16bd & ~bd_prev_q;
  assign rx_fall = rx_prev_q & ~rx_s;
  assign decide  = tick && (cnt_q == SAMPLE_DECIDE);
  assign wrap    = tick && (cnt_q == TICK_WRAP);
  assign maj     = majority3(samp_a_q, samp_b_q, rx_s);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start edge, glitch rejection, bit counting, mid-stop exit.
  // NOTE: every comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (rx_fall) state_d = START;
      START: begin
        if (decide && maj) state_d = IDLE;
        else if (wrap)     state_d = DATA;
      end
      DATA:  if (wrap && (bit_q == LAST_BIT)) state_d = STOP;
      STOP:  if (decide) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: tick counter, samples, shift register, output handshake.
  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fe_d     = 1'b0;
    ov_d     = 1'b0;

    if (state_q == IDLE)  cnt_d = 4'd0;
    else if (tick)        cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;

    if (tick && (cnt_q == SAMPLE_A)) samp_a_d = rx_s;
    if (tick && (cnt_q == SAMPLE_B)) samp_b_d = rx_s;

    if (state_q == START && wrap) bit_d = '0;
    if (state_q == DATA  && wrap) bit_d = bit_q + BIT_W'(1);

    if (state_q == DATA && decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};

    // Consumer ack retires the held byte; a byte completing this cycle wins.
    if (valid_q && ack) valid_d = 1'b0;

    if (state_q == STOP && decide) begin
      if (maj) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ov_d    = valid_q & ~ack;
      end else begin
        fe_d = 1'b1;
      end
    end
  end

  // Datapath and edge-detect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      bit_q     <= '0;
      shift_q   <= '0;
      samp_a_q  <= 1'b1;
      samp_b_q  <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      busy_q    <= 1'b0;
      rx_prev_q <= 1'b1;
      bd_prev_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      samp_a_q  <= samp_a_d;
      samp_b_q  <= samp_b_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      busy_q    <= (state_d != IDLE);
      rx_prev_q <= rx_s;
      bd_prev_q <= clk_16bd;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign frame_err      = fe_q;
  assign overrun        = ov_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: 8N1 frames at 4 clk per tick
// (64 clk per bit), table-driven rows plus reset and glitch sequences.
module tb_uart_rx_oversampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_16bd;
  logic       rx;
  logic       ack;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int ph       = 0;

  uart_rx_oversampler #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_16bd       (clk_16bd),
    .rx             (rx),
    .ack            (ack),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the clock handler: one-clk-wide high every 4 clk.
  initial clk_16bd = 1'b0;
  always @(negedge clk) begin
    ph = (ph + 1) % 4;
    clk_16bd = (ph == 0);
  end

  // Count the one-cycle status pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait until the next negedge raises clk_16bd, so frame timing is fixed.
  task automatic align_tick();
    @(posedge clk);
    while (ph != 3) @(posedge clk);
  endtask

  // Drive one 8N1 frame. Start edge at cycle 0; the stop-bit decision lands
  // on the posedge before cycle 617, so data_out_valid is first seen at 617.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_done,
                            input logic chk_lat, input int abort_cyc);
    int b;
    align_tick();
    for (int cyc = 0; cyc < 640; cyc++) begin
      @(negedge clk);
      if (chk_lat && cyc == 616) check("valid_before_stop_decide", data_out_valid, 0);
      if (chk_lat && cyc == 617) check("valid_after_stop_decide", data_out_valid, 1);
      if (cyc == abort_cyc) begin
        rst = 1'b1;
        rx  = 1'b1;
        ack = 1'b0;
        return;
      end
      b   = cyc / 64;
      rx  = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : stop;
      ack = ack_done && (cyc == 616);
    end
    @(negedge clk);
    rx  = 1'b1;
    ack = 1'b0;
    repeat (64) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack_done;
    logic       ack_after;
    logic       chk_lat;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int fe0, ov0;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 0};
    vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 0, 0};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 0, 0};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 0, 1};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 1};
    vecs[7] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 0, 0};

    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 0);
    check("reset_valid", data_out_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].ack_done, vecs[i].chk_lat, -1);
      check($sformatf("row%0d_data", i), data_out, vecs[i].exp_data);
      check($sformatf("row%0d_valid", i), data_out_valid, vecs[i].exp_valid);
      check($sformatf("row%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("row%0d_overrun", i), ov_cnt - ov0, vecs[i].exp_ov);
      check($sformatf("row%0d_busy", i), busy, 0);
      if (vecs[i].ack_after) begin
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check($sformatf("row%0d_ack_clears", i), data_out_valid, 0);
        repeat (4) @(negedge clk);
      end
    end

    // Reset in the middle of data bit 3 of 0x0F while 0x81 is still held.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 288);
    repeat (3) @(negedge clk);
    check("midrst_data_out", data_out, 0);
    check("midrst_valid", data_out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    rst = 1'b0;
    repeat (64) @(negedge clk);
    check("midrst_idle_busy", busy, 0);
    send_frame(8'hF0, 1'b1, 1'b0, 1'b1, -1);
    check("after_rst_data", data_out, 8'hF0);
    check("after_rst_valid", data_out_valid, 1);

    // Four-tick low glitch: rejected at the START decision (cycle 41).
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    align_tick();
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (cyc == 10) check("glitch_busy_rises", busy, 1);
      if (cyc == 40) check("glitch_busy_held", busy, 1);
      if (cyc == 41) check("glitch_busy_falls", busy, 0);
      rx = (cyc < 16) ? 1'b0 : 1'b1;
    end
    check("glitch_data", data_out, 8'hF0);
    check("glitch_valid", data_out_valid, 1);
    check("glitch_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
